// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning matrix keypad decoder with frame debounce,
// press/release/roll-over events and optional auto-repeat.
module keypad_scanner #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_EN    = 0,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [ROWS-1:0]               row_n,
   output logic [COLS-1:0]               col_n,
   output logic                          key_down,
   output logic                          key_repeat,
   output logic                          key_up,
   output logic [$clog2(ROWS*COLS)-1:0]  key_code,
   output logic                          key_held,
   output logic                          multi_key
);
   localparam int N    = ROWS * COLS;
   localparam int CW   = $clog2(N);
   localparam int SW   = $clog2(SCAN_DIV);
   localparam int LW   = $clog2(COLS);
   localparam int DW   = $clog2(DEBOUNCE + 1);
   localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   typedef enum logic [1:0] {C_NONE, C_ONE, C_MULTI} cls_t;
   typedef enum logic [1:0] {S_IDLE, S_HELD, S_ROLL} state_t;

   logic [ROWS-1:0] r_sync1, r_sync2;
   logic [SW-1:0]   r_slot;
   logic [LW-1:0]   r_col;
   logic [N-1:0]    r_frame;
   cls_t            r_cand_cls, r_com_cls;
   logic [CW-1:0]   r_cand_code, r_com_code, r_next;
   logic [DW-1:0]   r_cnt;
   state_t          r_state;
   logic [RW-1:0]   r_rep;
   logic            r_rep_after;

   logic            w_slot_end, w_frame_end, w_same, w_commit, w_rep_hit, w_rep_tick;
   logic [N-1:0]    w_acc;
   logic [1:0]      w_n;
   logic [CW-1:0]   w_idx, w_ccode;
   cls_t            w_cls;
   logic [DW-1:0]   w_cnt_nxt;
   logic [RW-1:0]   w_rep_nxt;

   assign col_n = ~(COLS'(1) << r_col);

   always_comb begin
      w_slot_end  = r_slot == SW'(SCAN_DIV - 1);
      w_frame_end = w_slot_end && r_col == LW'(COLS - 1);
      w_acc = r_frame;
      for (int r = 0; r < ROWS; r++)
         if (!r_sync2[r]) w_acc[r*COLS + int'(r_col)] = 1'b1;
      // popcount saturates at 2: only none/one/many matters
      w_n   = 2'd0;
      w_idx = '0;
      for (int i = 0; i < N; i++)
         if (w_acc[i]) begin
            w_idx = CW'(i);
            w_n   = w_n == 2'd2 ? 2'd2 : w_n + 2'd1;
         end
      w_cls      = w_n == 2'd0 ? C_NONE : w_n == 2'd1 ? C_ONE : C_MULTI;
      w_ccode    = w_cls == C_ONE ? w_idx : '0;
      w_same     = w_cls == r_cand_cls && w_ccode == r_cand_code;
      w_cnt_nxt  = !w_same ? DW'(1) : r_cnt == DW'(DEBOUNCE) ? r_cnt : r_cnt + DW'(1);
      w_commit   = w_frame_end && w_cnt_nxt == DW'(DEBOUNCE) &&
                   (w_cls != r_com_cls || w_ccode != r_com_code);
      w_rep_nxt  = r_rep + RW'(1);
      w_rep_hit  = w_rep_nxt == (r_rep_after ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY));
      w_rep_tick = REPEAT_EN != 0 && w_frame_end && r_state == S_HELD && !multi_key && !w_commit;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sync1     <= '1;
         r_sync2     <= '1;
         r_slot      <= '0;
         r_col       <= '0;
         r_frame     <= '0;
         r_cand_cls  <= C_NONE;
         r_cand_code <= '0;
         r_cnt       <= '0;
         r_com_cls   <= C_NONE;
         r_com_code  <= '0;
         r_next      <= '0;
         r_state     <= S_IDLE;
         r_rep       <= '0;
         r_rep_after <= 1'b0;
         key_down    <= 1'b0;
         key_up      <= 1'b0;
         key_repeat  <= 1'b0;
         key_held    <= 1'b0;
         multi_key   <= 1'b0;
         key_code    <= '0;
      end else begin
         r_sync1 <= row_n;
         r_sync2 <= r_sync1;
         r_slot  <= w_slot_end ? '0 : r_slot + SW'(1);
         if (w_slot_end) r_col <= r_col == LW'(COLS - 1) ? '0 : r_col + LW'(1);
         r_frame <= w_frame_end ? '0 : w_slot_end ? w_acc : r_frame;
         if (w_frame_end) begin
            r_cand_cls  <= w_cls;
            r_cand_code <= w_ccode;
            r_cnt       <= w_cnt_nxt;
         end
         key_down   <= 1'b0;
         key_up     <= 1'b0;
         key_repeat <= 1'b0;
         // roll-over: the new key's press follows the old key's release by one cycle
         if (r_state == S_ROLL) begin
            key_down <= 1'b1;
            key_held <= 1'b1;
            key_code <= r_next;
            r_state  <= S_HELD;
         end else if (w_commit) begin
            r_com_cls  <= w_cls;
            r_com_code <= w_ccode;
            multi_key  <= w_cls == C_MULTI;
            if (r_state == S_IDLE && w_cls == C_ONE) begin
               key_down <= 1'b1;
               key_held <= 1'b1;
               key_code <= w_ccode;
               r_state  <= S_HELD;
            end else if (r_state == S_HELD && w_cls == C_NONE) begin
               key_up      <= 1'b1;
               key_held    <= 1'b0;
               r_state     <= S_IDLE;
               r_rep       <= '0;
               r_rep_after <= 1'b0;
            end else if (r_state == S_HELD && w_cls == C_ONE && w_ccode != key_code) begin
               key_up      <= 1'b1;
               key_held    <= 1'b0;
               r_next      <= w_ccode;
               r_state     <= S_ROLL;
               r_rep       <= '0;
               r_rep_after <= 1'b0;
            end
         end else if (w_rep_tick) begin
            if (w_rep_hit) begin
               key_down    <= 1'b1;
               key_repeat  <= 1'b1;
               r_rep       <= '0;
               r_rep_after <= 1'b1;
            end else
               r_rep <= w_rep_nxt;
         end
      end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-by-frame vector table against a behavioural keypad
// matrix, plus hand sequences for reset and mid-hold reset.
module tb_keypad_scanner;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_n, col_n, key_code;
   logic        key_down, key_repeat, key_up, key_held, multi_key;
   logic [15:0] keys = '0;
   int          total = 0, bad = 0, cyc = 0;

   typedef struct {
      logic [15:0] keys;
      logic        dn, up, rp, held, mk;
      logic [3:0]  code;
      logic        mid;
   } vec_t;
   vec_t tv[$];

   keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_EN(1),
                    .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
      .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .key_down(key_down),
      .key_repeat(key_repeat), .key_up(key_up), .key_code(key_code),
      .key_held(key_held), .multi_key(multi_key));

   always #5 clk = ~clk;

   // a pressed key (bit row*4+col) pulls its row low while its column is driven
   always_comb
      for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);

   function automatic vec_t v(input logic [15:0] k, input logic dn, up, rp, hd, mk,
                              input logic [3:0] c, input logic md);
      vec_t t;
      t.keys = k; t.dn = dn; t.up = up; t.rp = rp; t.held = hd; t.mk = mk; t.code = c; t.mid = md;
      return t;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
      end
   endtask

   task automatic tick();
      logic [3:0] e;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      e = ~(4'b0001 << ((cyc / 4) % 4));
      chk("col_n", col_n, e);
   endtask

   task automatic chk_reset_outputs();
      chk("rst key_down", key_down, 0);
      chk("rst key_up", key_up, 0);
      chk("rst key_repeat", key_repeat, 0);
      chk("rst key_held", key_held, 0);
      chk("rst multi_key", multi_key, 0);
      chk("rst key_code", key_code, 0);
      chk("rst col_n", col_n, 4'b1110);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nd, nu, nb;
      logic [3:0] mcode;
      // press 9 cleanly, release
      tv.push_back(v(16'h0200, 0,0,0,0,0, 0, 0));
      tv.push_back(v(16'h0200, 0,0,0,0,0, 0, 0));
      tv.push_back(v(16'h0200, 1,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0200, 0,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0000, 0,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0000, 0,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0000, 0,1,0,0,0, 9, 0));
      // bounce, then stable
      tv.push_back(v(16'h0200, 0,0,0,0,0, 9, 0));
      tv.push_back(v(16'h0000, 0,0,0,0,0, 9, 0));
      tv.push_back(v(16'h0200, 0,0,0,0,0, 9, 0));
      tv.push_back(v(16'h0000, 0,0,0,0,0, 9, 0));
      tv.push_back(v(16'h0200, 0,0,0,0,0, 9, 0));
      tv.push_back(v(16'h0200, 0,0,0,0,0, 9, 0));
      tv.push_back(v(16'h0200, 1,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0000, 0,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0000, 0,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0000, 0,1,0,0,0, 9, 0));
      // multi 9+10 from idle, then drop to 9
      tv.push_back(v(16'h0600, 0,0,0,0,0, 9, 0));
      tv.push_back(v(16'h0600, 0,0,0,0,0, 9, 0));
      tv.push_back(v(16'h0600, 0,0,0,0,1, 9, 0));
      tv.push_back(v(16'h0200, 0,0,0,0,1, 9, 0));
      tv.push_back(v(16'h0200, 0,0,0,0,1, 9, 0));
      tv.push_back(v(16'h0200, 1,0,0,1,0, 9, 0));
      // roll-over 9 -> 5: release now, press one cycle later
      tv.push_back(v(16'h0020, 0,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0020, 0,0,0,1,0, 9, 0));
      tv.push_back(v(16'h0020, 0,1,0,0,0, 9, 0));
      tv.push_back(v(16'h0020, 0,0,0,1,0, 5, 1));
      tv.push_back(v(16'h0000, 0,0,0,1,0, 5, 0));
      tv.push_back(v(16'h0000, 0,0,0,1,0, 5, 0));
      tv.push_back(v(16'h0000, 0,1,0,0,0, 5, 0));
      // hold 0: press, repeat after 4 frames, then every 2
      tv.push_back(v(16'h0001, 0,0,0,0,0, 5, 0));
      tv.push_back(v(16'h0001, 0,0,0,0,0, 5, 0));
      tv.push_back(v(16'h0001, 1,0,0,1,0, 0, 0));
      tv.push_back(v(16'h0001, 0,0,0,1,0, 0, 0));
      tv.push_back(v(16'h0001, 0,0,0,1,0, 0, 0));
      tv.push_back(v(16'h0001, 0,0,0,1,0, 0, 0));
      tv.push_back(v(16'h0001, 1,0,1,1,0, 0, 0));
      tv.push_back(v(16'h0001, 0,0,0,1,0, 0, 0));
      tv.push_back(v(16'h0001, 1,0,1,1,0, 0, 0));
      tv.push_back(v(16'h0001, 0,0,0,1,0, 0, 0));
      tv.push_back(v(16'h0001, 1,0,1,1,0, 0, 0));
      tv.push_back(v(16'h0001, 0,0,0,1,0, 0, 0));

      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;
      cyc   = 0;

      foreach (tv[s]) begin
         keys = tv[s].keys;
         nd = 0; nu = 0; nb = 0; mcode = '0;
         for (int j = 1; j <= 16; j++) begin
            tick();
            if (j < 16) begin
               if (key_down) begin nd++; mcode = key_code; end
               if (key_up) nu++;
            end
            if (key_down && key_up) nb++;
         end
         chk($sformatf("f%0d key_down", s), key_down, tv[s].dn);
         chk($sformatf("f%0d key_up", s), key_up, tv[s].up);
         chk($sformatf("f%0d key_repeat", s), key_repeat, tv[s].rp);
         chk($sformatf("f%0d key_held", s), key_held, tv[s].held);
         chk($sformatf("f%0d multi_key", s), multi_key, tv[s].mk);
         chk($sformatf("f%0d key_code", s), key_code, tv[s].code);
         chk($sformatf("f%0d mid-frame downs", s), nd, tv[s].mid);
         chk($sformatf("f%0d mid-frame ups", s), nu, 0);
         chk($sformatf("f%0d up&down overlap", s), nb, 0);
         if (tv[s].mid) chk($sformatf("f%0d roll-over code", s), mcode, tv[s].code);
      end

      // reset mid-hold: immediate return to reset values, no release event
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      keys = '0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("in-reset key_up", key_up, 0);
         chk("in-reset key_held", key_held, 0);
      end
      rst_n = 1'b1;
      cyc   = 0;
      nd = 0; nu = 0;
      repeat (64) begin
         tick();
         nd += int'(key_down);
         nu += int'(key_up);
      end
      chk("post-reset downs", nd, 0);
      chk("post-reset ups", nu, 0);
      chk("post-reset key_held", key_held, 0);
      chk("post-reset key_code", key_code, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
